// File: rtl/fpg8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpg8_pkg                                                     |
// | Description : Shared definitions for the serial program loader: frame     |
// |               constants and the loader state encoding.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fpg8_pkg;

  // Default frame start marker.
  localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

  // SYNC, LEN_HI and LEN_LO precede the payload.
  localparam int C_HEADER_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_WRITE   = 3'd5,
    ST_CHECK   = 3'd6
  } loader_state_t;

endpackage : fpg8_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : 8N1 UART receiver, LSB first, with a 2-flop input           |
// |               synchroniser and centre-of-bit sampling.                     |
// | Ports       : clk        - system clock                                    |
// |               reset      - asynchronous active-low reset                   |
// |               rx         - serial input, idle high, asynchronous to clk    |
// |               byte_valid - 1-cycle pulse, byte_data holds a good byte      |
// |               byte_data  - last received byte                              |
// |               frame_err  - 1-cycle pulse when the stop bit reads low       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    U_IDLE  = 3'd0,
    U_START = 3'd1,
    U_DATA  = 3'd2,
    U_STOP  = 3'd3,
    U_REARM = 3'd4
  } uart_state_t;

  uart_state_t      r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic [7:0]       r_byte_data;
  logic             r_frame_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_state      <= U_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= rx;
      r_sync2      <= r_sync1;
      r_rx_prev    <= r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        U_IDLE: begin
          // Start bit: falling edge on the synchronised line.
          if (r_rx_prev && !r_sync2) begin
            r_cnt   <= '0;
            r_state <= U_START;
          end
        end
        U_START: begin
          if (r_cnt == C_HALF_LAST) begin
            r_cnt <= '0;
            // Line back high at mid start bit means a glitch; line is
            // already high so the receiver is re-armed.
            if (r_sync2) begin
              r_state <= U_IDLE;
            end else begin
              r_bit_idx <= 3'd0;
              r_state   <= U_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= U_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
              r_state      <= U_IDLE;
            end else begin
              // Low stop bit: wait for the line to return high before
              // looking for another start edge.
              r_frame_err <= 1'b1;
              r_state     <= U_REARM;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_REARM: begin
          if (r_sync2) begin
            r_state <= U_IDLE;
          end
        end
        default: r_state <= U_IDLE;
      endcase
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign frame_err  = r_frame_err;

endmodule : uart_rx
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_loader                                                   |
// | Description : Serial program loader. Receives a framed image over UART    |
// |               and writes it word by word into the program RAM.            |
// |               Frame: SYNC, LEN_HI, LEN_LO, LEN x (hi, lo), CHK where CHK  |
// |               is the XOR of all payload bytes.                             |
// | Ports       : clk        - free-running system clock                       |
// |               reset      - asynchronous active-low reset                   |
// |               rx         - UART receive line (8N1, idle high)              |
// |               ram_w_en   - 1-cycle RAM write strobe                        |
// |               ram_addr   - RAM write address                               |
// |               ram_w_data - RAM write data                                  |
// |               busy       - frame in progress (holds the CPU in reset)      |
// |               done       - sticky: last frame loaded, checksum good        |
// |               err        - sticky: last frame aborted                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ram_loader
  import fpg8_pkg::*;
#(
  parameter int         CLK_HZ     = 12000000,
  parameter int         BAUD       = 115200,
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] SYNC_BYTE  = C_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_w_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Must come out at 4 or more for the receiver's half-bit timing.
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int C_MAX_LEN    = 1 << ADDR_WIDTH;
  // One extra bit so a full-RAM image (2^ADDR_WIDTH words) is representable.
  localparam int REM_W        = ADDR_WIDTH + 1;

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_frame_err;
  logic [15:0] w_len;

  loader_state_t         r_state;
  logic [7:0]            r_len_hi;
  logic [REM_W-1:0]      r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_data;
  logic [7:0]            r_chk;
  logic                  r_w_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte),
    .frame_err  (w_frame_err)
  );

  assign w_len = {r_len_hi, w_byte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_len_hi    <= 8'd0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_data      <= 16'd0;
      r_chk       <= 8'd0;
      r_w_en      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      // A broken byte anywhere inside a frame aborts it; words already
      // written are left in RAM.
      if (w_frame_err && (r_state != ST_IDLE)) begin
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte_valid && (w_byte == SYNC_BYTE)) begin
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_err   <= 1'b0;
              r_addr  <= '0;
              r_chk   <= 8'd0;
              r_state <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (w_byte_valid) begin
              r_len_hi <= w_byte;
              r_state  <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (w_byte_valid) begin
              if (int'(w_len) > C_MAX_LEN) begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else if (w_len == 16'd0) begin
                r_state <= ST_CHECK;
              end else begin
                r_remaining <= REM_W'(w_len);
                r_state     <= ST_DATA_HI;
              end
            end
          end
          ST_DATA_HI: begin
            if (w_byte_valid) begin
              r_data[15:8] <= w_byte;
              r_chk        <= r_chk ^ w_byte;
              r_state      <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            if (w_byte_valid) begin
              r_data[7:0] <= w_byte;
              r_chk       <= r_chk ^ w_byte;
              r_w_en      <= 1'b1;
              r_state     <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            // Strobe is high for exactly this cycle; address advances after
            // it. A full-RAM image wraps the address back to 0 here.
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == REM_W'(1)) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_DATA_HI;
            end
          end
          ST_CHECK: begin
            if (w_byte_valid) begin
              if (w_byte == r_chk) begin
                r_done <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ram_w_en   = r_w_en;
  assign ram_addr   = r_addr;
  assign ram_w_data = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule : ram_loader
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_loader                                                |
// | Description : Self-checking bench for ram_loader. Frames are serialised   |
// |               onto rx; a frame-level model predicts the RAM writes and    |
// |               the final status flags.                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ram_loader;

  localparam int CPB = 12;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        ram_w_en;
  logic [11:0] ram_addr;
  logic [15:0] ram_w_data;
  logic        busy;
  logic        done;
  logic        err;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  strobe_viol = 0;
  int  both_set = 0;
  logic prev_wen = 1'b0;
  bit  m_done = 1'b0;
  bit  m_err = 1'b0;

  ram_loader #(
    .CLK_HZ     (12000000),
    .BAUD       (1000000),
    .ADDR_WIDTH (12),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .ram_w_en   (ram_w_en),
    .ram_addr   (ram_addr),
    .ram_w_data (ram_w_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write capture and invariant watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_w_en) got_q.push_back({ram_addr, ram_w_data});
    if (ram_w_en && (prev_wen || !busy)) strobe_viol++;
    if (done && err) both_set++;
    prev_wen = ram_w_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!good_stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_seq(input byte_q_t f, input int bad);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], i != bad);
    repeat (3 * CPB) @(negedge clk);
  endtask

  // Frame-level prediction: locate SYNC, read the length, emit one write
  // per complete word, then judge the checksum. A bad-stop byte ends the
  // frame at that point.
  task automatic model(input byte_q_t b, input int bad);
    int s, stop, len, nw;
    logic [7:0] chk;
    exp_q.delete();
    s = -1;
    for (int i = 0; i < b.size(); i++)
      if (s < 0 && i != bad && b[i] == 8'hA5) s = i;
    if (s < 0) return;
    m_done = 1'b0;
    m_err  = 1'b0;
    stop = (bad > s) ? bad : b.size();
    if (stop < s + 3) begin m_err = 1'b1; return; end
    len = int'({b[s+1], b[s+2]});
    if (len > 4096) begin m_err = 1'b1; return; end
    nw = (stop - (s + 3)) / 2;
    if (nw > len) nw = len;
    chk = 8'd0;
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back('{a: 12'(w), d: {b[s+3+2*w], b[s+4+2*w]}});
      chk = chk ^ b[s+3+2*w] ^ b[s+4+2*w];
    end
    if (bad > s) m_err = 1'b1;
    else if (b[s+3+2*len] == chk) m_done = 1'b1;
    else m_err = 1'b1;
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s nwr", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), got_q[i], exp_q[i]);
    check($sformatf("%s done", tag), done, m_done);
    check($sformatf("%s err", tag), err, m_err);
    check($sformatf("%s busy", tag), busy, 1'b0);
  endtask

  task automatic run(input byte_q_t f, input int bad, input string tag);
    got_q.delete();
    send_seq(f, bad);
    model(f, bad);
    compare(tag);
  endtask

  initial begin
    byte_q_t f;
    int      nj, len, bad;
    logic [7:0] c, d;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst w_en", ram_w_en, 1'b0);
    check("rst addr", ram_addr, 12'd0);
    check("rst data", ram_w_data, 16'd0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 1 with busy observed mid-frame
    got_q.delete();
    send_byte(8'hA5, 1'b1);
    repeat (CPB) @(negedge clk);
    check("f1 busy mid", busy, 1'b1);
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_seq(f[1:$], -1);
    model(f, -1);
    compare("f1");

    // Bad checksum: writes still happen
    run('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, -1, "badchk");

    // Leading junk ignored
    got_q.delete();
    send_seq('{8'h00, 8'h55, 8'hFF}, -1);
    check("junk busy", busy, 1'b0);
    check("junk nwr", got_q.size(), 0);
    run('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51}, -1, "beef");

    // Length one past the RAM size; then exactly the RAM size (aborted
    // after one word so the run stays short)
    run('{8'hA5, 8'h10, 8'h01}, -1, "len4097");
    run('{8'hA5, 8'h10, 8'h00, 8'h12, 8'h34, 8'h56}, 5, "len4096");

    // Empty image
    run('{8'hA5, 8'h00, 8'h00, 8'h00}, -1, "len0");

    // Framing error mid-frame, then recovery
    run('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34}, 4, "ferr");
    run('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51}, -1, "recov");

    // Reset between the two bytes of the first word
    got_q.delete();
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h12}, -1);
    check("pre-rst busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("arst busy", busy, 1'b0);
    check("arst data", ram_w_data, 16'd0);
    check("arst addr", ram_addr, 12'd0);
    check("arst done", done, 1'b0);
    check("arst err", err, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_done = 1'b0;
    m_err  = 1'b0;
    repeat (2) @(negedge clk);
    check("arst nwr", got_q.size(), 0);
    run('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, -1, "f1again");

    // Randomised frames
    for (int it = 0; it < 5; it++) begin
      f.delete();
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        do d = 8'($urandom); while (d == 8'hA5);
        f.push_back(d);
      end
      len = $urandom_range(0, 4);
      f.push_back(8'hA5);
      f.push_back(8'(len >> 8));
      f.push_back(8'(len));
      c = 8'd0;
      for (int j = 0; j < 2 * len; j++) begin
        d = 8'($urandom);
        c = c ^ d;
        f.push_back(d);
      end
      if ($urandom_range(0, 1) == 1) c = c ^ (8'h01 << $urandom_range(0, 7));
      f.push_back(c);
      bad = -1;
      if ($urandom_range(0, 2) == 0) begin
        bad = $urandom_range(nj + 1, f.size() - 1);
        while (f.size() > bad + 1) void'(f.pop_back());
      end
      run(f, bad, $sformatf("rnd%0d", it));
    end

    check("strobe rule", strobe_viol, 0);
    check("done&err", both_set, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_loader
`default_nettype wire
